demux_display: RTL
==================

Name: demux_display

Overview:
- Receiving end of the multiplexed 7-segment display bus; same domain as mux_Display.
- Watches the scanned digit-enable and segment lines (ED/D bus) and rebuilds the four per-digit segment patterns. Decodes each pattern back to a hex nibble.
- Reports frame completion, illegal enable patterns and loss of scanning.
- Used as a self-check and loopback monitor for mux_Display, and as a capture block for external scanned displays.

Parameters:
- SETTLE, 4: consecutive clock edges a digit enable must be held before its segments are captured; legal range 1..255.
- TIMEOUT, 65535: clock cycles without any capture before stale asserts; legal range 1..2^20-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ED_in  in  4  digit enables, active-low one-hot; bit i low selects digit i.
- D_in  in  7  segments, active-low; bit6=a, bit5=b, …, bit0=g.
- Q0..Q3  out  7 each  last captured raw segment pattern for digits 0..3.
- H0..H3  out  4 each  hex value decoded from Q0..Q3.
- hex_ok  out  4  bit i=1 when Qi is a recognised hex glyph.
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the last pulse.
- err_sel  out  1  one-cycle pulse on an illegal enable pattern.
- stale  out  1  level; no capture for TIMEOUT cycles.

Behaviour:
- Clocking and reset:
  - Single clock domain; ED_in and D_in are synchronous to clock. All outputs are registered.
  - Reset is synchronous and active-high and has priority over all other actions, including mid-dwell or mid-frame.
  - Reset values: Q0..Q3=7'h7F, H0..H3=0, hex_ok=0, frame_done=0, err_sel=0, stale=0.
  - Internal reset values: last_ed=4'hF, dwell count=0, seen mask=0, idle count=0.
- Input classification, evaluated on every edge:
  - VALID: exactly one bit of ED_in is 0.
  - BLANK: ED_in=4'hF.
  - ILLEGAL: anything else.
- Dwell counter (cnt, saturates at SETTLE):
  - VALID and ED_in==last_ed: cnt<=cnt+1 (saturating).
  - VALID and ED_in!=last_ed: cnt<=1.
  - BLANK or ILLEGAL: cnt<=0.
  - last_ed<=ED_in on every edge.
- Capture:
  - Occurs on the edge where cnt becomes SETTLE; exactly once per dwell.
  - With SETTLE=1, capture occurs on the first edge that samples a new valid enable.
  - The selected Qi takes D_in as sampled on that edge. Hi and hex_ok[i] update on the same edge, so there is no extra latency.
  - Digits that are not selected hold their values.
- Hex decode table (Q value → H):
  - 01→0, 4F→1, 12→2, 06→3, 4C→4, 24→5, 20→6, 0F→7.
  - 00→8, 04→9, 08→A, 60→b, 31→C, 42→d, 30→E, 38→F.
  - Any other pattern: H=0, hex_ok=0.
- Frame tracking:
  - A capture of digit i sets seen[i]. Digits may arrive in any order, and repeats are harmless.
  - On the capture edge that makes seen=4'hF: frame_done=1 for one cycle and seen<=0 on the same edge.
- Errors:
  - ILLEGAL sampled: err_sel=1 on that edge, for one cycle per ILLEGAL sample. seen and Q are unchanged.
  - BLANK is legal inter-digit blanking; no error.
- Stale:
  - Idle counter increments every cycle without a capture and saturates at TIMEOUT.
  - stale=1 once the counter reaches TIMEOUT.
  - A capture clears both the counter and stale on that edge.
- Simultaneous events:
  - A capture that completes a frame also clears stale and pulses frame_done in the same cycle.
  - A capture and an ILLEGAL sample cannot coincide.

Test Plan:
- Loopback with mux_Display, SETTLE=4, digits 0..3 driven with 7'h01, 7'h4F, 7'h12, 7'h06 → after one full scan Q0..Q3 equal those values, H0..H3=0,1,2,3, hex_ok=4'hF, and frame_done pulses once per full scan.
- ED_in held at 4'b1101 (digit 1) for exactly 3 edges, then 4'hF, with SETTLE=4 → no capture; Q1 stays 7'h7F. Held for 4 edges → Q1=D_in on the 4th edge.
- Glyph decode: drive digit 2 with 7'h78, then 7'h38 → first capture gives Q2=7'h78, H2=0, hex_ok[2]=0; second gives H2=4'hF, hex_ok[2]=1.
- ED_in=4'b0101 for 2 edges mid-frame → err_sel high for 2 cycles; Q and seen unchanged; frame_done only after the remaining digits are captured.
- TIMEOUT=16 with ED_in=4'hF → stale=1 on cycle 16 after the last capture; the next valid dwell clears stale on its capture edge.
- Reset asserted mid-dwell with seen=4'b0111 → all outputs return to reset values on the next edge; a following capture of digit 3 alone does not pulse frame_done.

Source files
------------

// File: rtl/demux_display.sv
// demux_display: rebuilds and hex-decodes four digits from a scanned active-low 7-segment bus
module demux_display #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] ED_in,
  input  logic [6:0] D_in,
  output logic [6:0] Q0,
  output logic [6:0] Q1,
  output logic [6:0] Q2,
  output logic [6:0] Q3,
  output logic [3:0] H0,
  output logic [3:0] H1,
  output logic [3:0] H2,
  output logic [3:0] H3,
  output logic [3:0] hex_ok,
  output logic       frame_done,
  output logic       err_sel,
  output logic       stale
);
  localparam logic [7:0]  S = 8'(SETTLE);
  localparam logic [19:0] T = 20'(TIMEOUT);
  logic [6:0]  q_q [4], q_d [4];
  logic [3:0]  h_q [4], h_d [4];
  logic [3:0]  ok_q, ok_d, seen_q, seen_d, last_ed_q, last_ed_d, seen_set;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] idle_q, idle_d;
  logic        frame_q, frame_d, err_q, err_d, stale_q, stale_d;
  logic        valid, same, cap;
  logic [1:0]  idx;
  logic [4:0]  dec;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h01: decode = 5'h10; 7'h4F: decode = 5'h11; 7'h12: decode = 5'h12; 7'h06: decode = 5'h13;
      7'h4C: decode = 5'h14; 7'h24: decode = 5'h15; 7'h20: decode = 5'h16; 7'h0F: decode = 5'h17;
      7'h00: decode = 5'h18; 7'h04: decode = 5'h19; 7'h08: decode = 5'h1A; 7'h60: decode = 5'h1B;
      7'h31: decode = 5'h1C; 7'h42: decode = 5'h1D; 7'h30: decode = 5'h1E; 7'h38: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction
  always_comb begin
    valid     = (ED_in == 4'b1110) || (ED_in == 4'b1101) || (ED_in == 4'b1011) || (ED_in == 4'b0111);
    same      = ED_in == last_ed_q;
    cnt_d     = !valid ? 8'd0 : !same ? 8'd1 : (cnt_q == S) ? cnt_q : cnt_q + 8'd1;
    // a dwell already parked at SETTLE must not capture again
    cap       = valid && (cnt_d == S) && !(same && cnt_q == S);
    idx       = !ED_in[0] ? 2'd0 : !ED_in[1] ? 2'd1 : !ED_in[2] ? 2'd2 : 2'd3;
    dec       = decode(D_in);
    q_d       = q_q;
    h_d       = h_q;
    ok_d      = ok_q;
    if (cap) begin
      q_d[idx]  = D_in;
      h_d[idx]  = dec[3:0];
      ok_d[idx] = dec[4];
    end
    seen_set  = seen_q | (cap ? ~ED_in : 4'h0);
    frame_d   = cap && (seen_set == 4'hF);
    seen_d    = frame_d ? 4'h0 : seen_set;
    err_d     = !valid && (ED_in != 4'hF);
    idle_d    = cap ? 20'd0 : (idle_q == T) ? idle_q : idle_q + 20'd1;
    stale_d   = idle_d == T;
    last_ed_d = ED_in;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q       <= '{4{7'h7F}};
      h_q       <= '{4{4'h0}};
      ok_q      <= 4'h0;
      seen_q    <= 4'h0;
      last_ed_q <= 4'hF;
      cnt_q     <= 8'd0;
      idle_q    <= 20'd0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      q_q       <= q_d;
      h_q       <= h_d;
      ok_q      <= ok_d;
      seen_q    <= seen_d;
      last_ed_q <= last_ed_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
    end
  end
  assign Q0         = q_q[0];
  assign Q1         = q_q[1];
  assign Q2         = q_q[2];
  assign Q3         = q_q[3];
  assign H0         = h_q[0];
  assign H1         = h_q[1];
  assign H2         = h_q[2];
  assign H3         = h_q[3];
  assign hex_ok     = ok_q;
  assign frame_done = frame_q;
  assign err_sel    = err_q;
  assign stale      = stale_q;
endmodule
